// File: rtl/load_store_unit.sv
// Load/store stage: turns decoded load/store controls into a single
// req/ack bus transaction and returns an aligned, extended load result.
//
// Bus handshake: bus_req is raised on the edge leaving IDLE and stays high,
// with bus_we/bus_addr/bus_wdata/bus_be stable, until the cycle in which
// bus_ack is sampled high in BUSY; it drops on that edge. bus_ack is a
// one-cycle strobe and is ignored outside BUSY.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_be,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        mis_addr;
  logic        access;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_c;

  assign state_dbg = state;

  // Alignment check, byte-enable and lane-replicated write data for the request
  always_comb begin
    mis_addr = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = store_data;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        mis_addr = addr[0];
        be_c     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{store_data[15:0]}};
      end
      default: begin
        mis_addr = (addr[1:0] != 2'b00);
      end
    endcase
  end

  assign misaligned = (mem_read | mem_write) & mis_addr;
  assign access     = (mem_read | mem_write) & ~mis_addr;

  // Lane selection and sign/zero extension of the returned read word
  always_comb begin
    byte_sel = bus_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   load_c = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_c = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_c = bus_rdata;
    endcase
  end

  // Next-state and stall: stall covers the issuing IDLE cycle and all of BUSY
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ack) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request latch in IDLE, completion and load capture in BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= 4'b0000;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      uns_q     <= 1'b0;
      load_data <= '0;
    end else begin
      if (state == IDLE && access) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        bus_wdata <= wdata_c;
        bus_be    <= be_c;
        size_q    <= mem_size;
        lane_q    <= addr[1:0];
        uns_q     <= mem_unsigned;
      end else if (state == BUSY && bus_ack) begin
        bus_req <= 1'b0;
        if (!bus_we) load_data <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall(stall), .misaligned(misaligned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: IDLE issue, waits+1 BUSY cycles, DONE, back to IDLE.
  // Inputs stay asserted through DONE so a re-issue would show up in IDLE.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic exp_we,
                           input logic [31:0] exp_load);
    int   stall_cycles;
    logic stable;
    exp_q.push_back(exp_load);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; store_data = sd;
    #1;
    check_eq({tag, " misaligned"}, 32'(misaligned), 32'd0);
    stall_cycles = int'(stall);
    stable = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      step;
      if (i == waits) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
      end else begin
        bus_rdata = ~rdata;
      end
      if (i == 0) begin
        check_eq({tag, " state_busy"}, 32'(state_dbg), 32'd1);
        check_eq({tag, " bus_req"}, 32'(bus_req), 32'd1);
        check_eq({tag, " bus_we"}, 32'(bus_we), 32'(exp_we));
        check_eq({tag, " bus_addr"}, bus_addr, exp_addr);
        check_eq({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
        check_eq({tag, " bus_wdata"}, bus_wdata, exp_wdata);
      end
      if (bus_req !== 1'b1 || bus_we !== exp_we || bus_addr !== exp_addr ||
          bus_be !== exp_be || bus_wdata !== exp_wdata)
        stable = 1'b0;
      stall_cycles += int'(stall);
    end
    check_eq({tag, " bus_stable"}, 32'(stable), 32'd1);
    step;
    bus_ack = 1'b0;
    check_eq({tag, " state_done"}, 32'(state_dbg), 32'd2);
    check_eq({tag, " done_stall"}, 32'(stall), 32'd0);
    check_eq({tag, " done_req"}, 32'(bus_req), 32'd0);
    check_eq({tag, " load_data"}, load_data, exp_q.pop_front());
    stall_cycles += int'(stall);
    check_eq({tag, " stall_cycles"}, 32'(stall_cycles), 32'(waits + 2));
    step;
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_eq({tag, " no_reissue_req"}, 32'(bus_req), 32'd0);
    check_eq({tag, " back_idle"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic check_misaligned(input string tag, input logic rd, input logic wr,
                                  input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] exp_load);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = 1'b0;
    addr = a; store_data = 32'h1234_5678;
    #1;
    check_eq({tag, " misaligned"}, 32'(misaligned), 32'd1);
    check_eq({tag, " stall"}, 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      check_eq({tag, " bus_req"}, 32'(bus_req), 32'd0);
    end
    check_eq({tag, " state"}, 32'(state_dbg), 32'd0);
    check_eq({tag, " load_data"}, load_data, exp_load);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00;
    mem_unsigned = 1'b0; addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    step;
    step;
    check_eq("rst bus_req", 32'(bus_req), 32'd0);
    check_eq("rst bus_we", 32'(bus_we), 32'd0);
    check_eq("rst bus_addr", bus_addr, 32'd0);
    check_eq("rst bus_wdata", bus_wdata, 32'd0);
    check_eq("rst bus_be", 32'(bus_be), 32'd0);
    check_eq("rst load_data", load_data, 32'd0);
    check_eq("rst state", 32'(state_dbg), 32'd0);
    check_eq("rst stall", 32'(stall), 32'd0);
    check_eq("rst misaligned", 32'(misaligned), 32'd0);
    rst_n = 1'b1;
    step;

    // tag rd wr size uns addr sdata rdata waits exp_addr be wdata we load
    do_access("lw",  1, 0, 2'b10, 0, 32'h104, 32'h0, 32'hDEADBEEF, 0,
              32'h104, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF);
    do_access("lb",  1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80112233, 0,
              32'h200, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80);
    do_access("lbu", 1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80112233, 1,
              32'h200, 4'b1000, 32'h0, 1'b0, 32'h00000080);
    do_access("sh",  0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'hFFFFFFFF, 3,
              32'h300, 4'b1100, 32'hABCDABCD, 1'b1, 32'h00000080);
    do_access("rw_sw", 1, 1, 2'b10, 0, 32'h500, 32'h12345678, 32'hFFFFFFFF, 0,
              32'h500, 4'b1111, 32'h12345678, 1'b1, 32'h00000080);
    do_access("lw_sz3", 1, 0, 2'b11, 0, 32'h600, 32'h0, 32'h8F0F0F0F, 2,
              32'h600, 4'b1111, 32'h0, 1'b0, 32'h8F0F0F0F);

    check_misaligned("mis_lw", 1, 0, 2'b10, 32'h101, 32'h8F0F0F0F);
    check_misaligned("mis_sh", 0, 1, 2'b01, 32'h103, 32'h8F0F0F0F);

    // reset while BUSY, then a late ack after release
    mem_read = 1'b1; mem_size = 2'b10; mem_unsigned = 1'b0; addr = 32'h400;
    #1;
    check_eq("rstbusy issue_stall", 32'(stall), 32'd1);
    step;
    check_eq("rstbusy state", 32'(state_dbg), 32'd1);
    check_eq("rstbusy req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstbusy req_drop", 32'(bus_req), 32'd0);
    check_eq("rstbusy state_idle", 32'(state_dbg), 32'd0);
    check_eq("rstbusy load_data", load_data, 32'd0);
    mem_read = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    step;
    bus_ack = 1'b0;
    check_eq("late_ack req", 32'(bus_req), 32'd0);
    check_eq("late_ack state", 32'(state_dbg), 32'd0);
    check_eq("late_ack load_data", load_data, 32'd0);

    // back-to-back: SB then LH issued in the IDLE cycle right after DONE
    do_access("sb",  0, 1, 2'b00, 0, 32'h10, 32'h00000055, 32'hFFFFFFFF, 0,
              32'h10, 4'b0001, 32'h55555555, 1'b1, 32'h0);
    do_access("lh",  1, 0, 2'b01, 0, 32'h12, 32'h0, 32'h80011234, 1,
              32'h10, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001);
    do_access("lhu", 1, 0, 2'b01, 1, 32'h20, 32'h0, 32'h1234F00D, 0,
              32'h20, 4'b0011, 32'h0, 1'b0, 32'h0000F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the control unit and ALU in the RV32I core. It consumes the decoded load/store controls (read/write enables, access size, unsigned flag) together with the ALU-computed address and the rs2 store data. It drives a word-wide req/ack data bus with byte enables, and returns an aligned, sign- or zero-extended load result to the writeback mux. While a bus transaction is outstanding, it stalls the core.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of the address input and of bus_addr

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load instruction in execute (ResultSrc = 01)
- mem_write  in  1  store instruction in execute (MemWrite)
- mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_unsigned  in  1  zero-extend load result (LBU/LHU)
- addr  in  ADDR_WIDTH  byte address from ALU result
- store_data  in  32  rs2 value
- load_data  out  32  registered, extended load result
- stall  out  1  hold PC/pipeline this cycle
- misaligned  out  1  combinational, access not naturally aligned
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_WIDTH  word-aligned address, addr with [1:0] = 00
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables, bit i = byte lane i
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe

## Operation
- The block uses three states: IDLE, BUSY and DONE.
- **IDLE behaviour:**
  - Access is defined as (mem_read | mem_write) & ~misaligned.
  - If access is set, stall = 1 (combinational). On the clock edge, the block latches we = mem_write, bus_addr, bus_be, bus_wdata, size and unsigned, sets bus_req = 1, and moves to BUSY.
  - If access is clear, stall = 0 and the state is unchanged.
- **BUSY behaviour:**
  - stall = 1. bus_req, bus_we, bus_addr, bus_wdata and bus_be are held stable.
  - On bus_ack: for a read, load_data is loaded from bus_rdata. bus_req is cleared and the state moves to DONE.
  - With no ack, BUSY is held indefinitely. There is no timeout.
- **DONE behaviour:** stall = 0 for exactly one cycle so the core commits and advances. The state moves to IDLE unconditionally. Inputs are not sampled in DONE, which prevents re-issue of the retiring instruction.
- **Misalignment:**
  - A half access is misaligned when addr[0] = 1. A word access is misaligned when addr[1:0] != 00.
  - When misaligned and (mem_read | mem_write): misaligned = 1, no bus transaction, stall = 0, load_data unchanged.
- **Read and write together:** if mem_read and mem_write are both 1, the write wins and the transaction is a store.
- **Byte enables (bus_be):**
  - Byte: 0001 shifted left by addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
- **Write data (bus_wdata):**
  - Byte: {4{store_data[7:0]}}.
  - Half: {2{store_data[15:0]}}.
  - Word: store_data.
- **Load extraction:**
  - The lane is selected by the latched addr[1:0] (byte) or addr[1] (half).
  - Byte and half results are sign-extended from bit 7 or 15, or zero-extended if unsigned. Word results pass through unchanged.
- **load_data retention:** load_data holds its value until the next completed load. Stores never modify it.

## Timing
- **Reset values:** state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0000, load_data 0. With state IDLE and no access, stall and misaligned follow their combinational definitions.
- **Reset in BUSY:** the transaction is abandoned and bus_req drops asynchronously. Late acks after reset release are ignored because bus_ack is sampled only in BUSY.
- **Zero-wait ack timing** (ack in the first BUSY cycle):
  - Cycle 0: IDLE, stall 1.
  - Cycle 1: BUSY, ack.
  - Cycle 2: DONE, stall 0, load_data valid.
  - The core is stalled for 2 cycles and each access takes 3 cycles.
- **N-wait ack:** stall lasts 2 + N cycles.
- **Bus protocol:** bus_req rises on the edge leaving IDLE. It falls on the edge after the ack is sampled, so it is low in DONE. Back-to-back requests are separated by at least DONE plus IDLE.
- **Latency:** load_data is valid from the DONE cycle onward.

## Test plan
- **LW, zero-wait:** addr = 0x104, bus_rdata = 0xDEADBEEF, ack in the first BUSY cycle -> bus_addr 0x104, be 1111, stall high for 2 cycles, load_data = 0xDEADBEEF in DONE.
- **LB and LBU:** addr = 0x203, bus_rdata = 0x80112233 -> LB gives load_data 0xFFFFFF80; LBU gives 0x00000080.
- **SH upper half:** addr = 0x302, store_data = 0x0000ABCD, 3 wait cycles -> bus_we 1, be 1100, wdata 0xABCDABCD stable for 4 BUSY cycles, stall 5 cycles, load_data unchanged.
- **Misaligned:** LW at addr = 0x101, and separately SH at addr = 0x103 -> misaligned 1, bus_req never asserted, stall 0, load_data unchanged.
- **Reset in BUSY:** rst_n pulled low during BUSY, then ack arrives after release -> bus_req 0 immediately, state IDLE, load_data 0, late ack ignored.
- **Back-to-back:** SB at addr = 0x10 with store_data 0x55, be 0001, followed by LH at addr = 0x12 -> second bus_req rises only after DONE and IDLE; no re-issue of the SB.
